// File: rtl/phys_reg_free_list.sv
// Physical-register free list: offers one tag per dispatch lane from the speculative mask,
// tracks a committed mask at retirement and restores the speculative mask on mispredict.
module phys_reg_free_list #(
  parameter  int N                = 3,
  parameter  int PHYS_REG_SZ_R10K = 64,
  parameter  int ARCH_REG_SZ      = 32,
  localparam int P                = PHYS_REG_SZ_R10K,
  localparam int TAG_W            = $clog2(P),
  localparam int CNT_W            = $clog2(P + 1)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N-1:0]                free_alloc_valid,
  output logic [N-1:0][P-1:0]         granted_regs,
  output logic [CNT_W-1:0]            free_slots_freelst,
  input  logic [N-1:0]                retire_valid,
  input  logic [N-1:0]                retire_uses_rd,
  input  logic [N-1:0][TAG_W-1:0]     retire_phys_rd,
  input  logic [N-1:0][TAG_W-1:0]     retire_told,
  input  logic                        mispredict
);

  localparam logic [P-1:0] RESET_IMG = {{(P - ARCH_REG_SZ){1'b1}}, {ARCH_REG_SZ{1'b0}}};

  logic [P-1:0] spec_free_q, spec_free_d;
  logic [P-1:0] comm_free_q, comm_free_d;
  logic [P-1:0] claimed;
  logic [P-1:0] freed;
  logic [P-1:0] remain;

  function automatic logic [CNT_W-1:0] popcnt(input logic [P-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int b = 0; b < P; b++) cnt = cnt + CNT_W'(v[b]);
    return cnt;
  endfunction

  // Each lane peels off the lowest remaining free bit, so grants are distinct and one-hot.
  always_comb begin
    remain  = spec_free_q;
    claimed = '0;
    for (int i = 0; i < N; i++) begin
      granted_regs[i] = remain & (-remain);
      remain          = remain & ~granted_regs[i];
      if (free_alloc_valid[i]) claimed = claimed | granted_regs[i];
    end
  end

  assign free_slots_freelst = popcnt(spec_free_q);

  // Lanes are applied in order so a later lane's told can free an earlier lane's phys_rd.
  always_comb begin
    comm_free_d = comm_free_q;
    freed       = '0;
    for (int i = 0; i < N; i++) begin
      if (retire_valid[i] && retire_uses_rd[i]) begin
        comm_free_d[retire_phys_rd[i]] = 1'b0;
        if (retire_told[i] != '0) begin
          comm_free_d[retire_told[i]] = 1'b1;
          freed[retire_told[i]]       = 1'b1;
        end
      end
    end
    spec_free_d = mispredict ? comm_free_d : ((spec_free_q & ~claimed) | freed);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      spec_free_q <= RESET_IMG;
      comm_free_q <= RESET_IMG;
    end else begin
      spec_free_q <= spec_free_d;
      comm_free_q <= comm_free_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        assert (!(free_alloc_valid[i] && (granted_regs[i] == '0)))
          else $error("free list: lane %0d requested with no tag offered", i);
      end
      assert ((freed & spec_free_q) == '0)
        else $error("free list: freeing a tag that is already free");
    end
  end

endmodule
